// File: rtl/bus_xfer_ctrl_if.sv
// Request handshake, register bus strobes and status signals for bus_xfer_ctrl.
interface bus_xfer_ctrl_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N_REGS = 8,
  parameter int unsigned SEL_W  = 3
);
  logic                    req_valid;
  logic                    req_ready;
  logic [SEL_W-1:0]        req_src;
  logic [SEL_W-1:0]        req_dst;
  logic                    req_imm;
  logic [WIDTH-1:0]        req_data;
  logic [N_REGS*WIDTH-1:0] regs_out;
  logic [N_REGS-1:0]       regs_en;
  logic [N_REGS-1:0]       assert_bus;
  logic [N_REGS-1:0]       load_bus;
  logic [WIDTH-1:0]        bus_value;
  logic                    done;
  logic [WIDTH-1:0]        done_data;
  logic                    err_contention;
  logic                    err_float;
  logic                    err_clear;

  // Requester / register-file side
  modport master (
    output req_valid, req_src, req_dst, req_imm, req_data,
    output regs_out, regs_en, err_clear,
    input  req_ready, assert_bus, load_bus, bus_value,
    input  done, done_data, err_contention, err_float
  );

  // Controller side
  modport slave (
    input  req_valid, req_src, req_dst, req_imm, req_data,
    input  regs_out, regs_en, err_clear,
    output req_ready, assert_bus, load_bus, bus_value,
    output done, done_data, err_contention, err_float
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register (or immediate-to-register) transfer sequencer for a
// shared wired-AND bus: IDLE -> DRIVE -> LOAD -> DONE, one transfer per 4 cycles.
module bus_xfer_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned N_REGS = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic          clk,
  input  logic          reset,
  bus_xfer_ctrl_if.slave bus
);

  // Wide enough to count every register driver plus the immediate driver.
  localparam int unsigned CNT_W = $clog2(N_REGS + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   src_q, src_d;
  logic [SEL_W-1:0]   dst_q, dst_d;
  logic               imm_q, imm_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               ready_q, ready_d;
  logic [N_REGS-1:0]  assert_q, assert_d;
  logic [N_REGS-1:0]  load_q, load_d;
  logic               imm_drv_q, imm_drv_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   done_data_q, done_data_d;
  logic               err_c_q, err_c_d;
  logic               err_f_q, err_f_d;

  logic [WIDTH-1:0]   bus_c;
  logic [CNT_W-1:0]   drv_cnt_c;
  logic               drive_d;

  // Wired-AND bus resolution with pull-up, plus a count of active drivers.
  always_comb begin
    bus_c     = '1;
    drv_cnt_c = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (bus.regs_en[i]) begin
        bus_c     = bus_c & bus.regs_out[i*WIDTH +: WIDTH];
        drv_cnt_c = drv_cnt_c + CNT_W'(1);
      end
    end
    if (imm_drv_q) begin
      bus_c     = bus_c & data_q;
      drv_cnt_c = drv_cnt_c + CNT_W'(1);
    end
  end

  // Next state, request latch, error flags and next-cycle strobe values.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    imm_d       = imm_q;
    data_d      = data_q;
    done_data_d = done_data_q;
    err_c_d     = err_c_q;
    err_f_d     = err_f_q;
    ready_d     = 1'b0;
    assert_d    = '1;
    load_d      = '1;
    imm_drv_d   = 1'b0;
    done_d      = 1'b0;
    drive_d     = 1'b0;

    // Clear first so that a simultaneous set below takes priority.
    if (bus.err_clear) begin
      err_c_d = 1'b0;
      err_f_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          src_d   = bus.req_src;
          dst_d   = bus.req_dst;
          imm_d   = bus.req_imm;
          data_d  = bus.req_data;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: state_d = S_LOAD;
      S_LOAD: begin
        state_d     = S_DONE;
        done_data_d = bus_c;
        if (drv_cnt_c >= CNT_W'(2)) err_c_d = 1'b1;
        if (drv_cnt_c == CNT_W'(0)) err_f_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they leave a flop directly.
    ready_d   = (state_d == S_IDLE);
    done_d    = (state_d == S_DONE);
    drive_d   = (state_d == S_DRIVE) || (state_d == S_LOAD);
    imm_drv_d = drive_d && imm_d;
    for (int i = 0; i < N_REGS; i++) begin
      if (drive_d && !imm_d && (src_d == SEL_W'(i))) assert_d[i] = 1'b0;
      if ((state_d == S_LOAD) && (dst_d == SEL_W'(i))) load_d[i] = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      imm_q       <= 1'b0;
      data_q      <= '0;
      ready_q     <= 1'b1;
      assert_q    <= '1;
      load_q      <= '1;
      imm_drv_q   <= 1'b0;
      done_q      <= 1'b0;
      done_data_q <= '0;
      err_c_q     <= 1'b0;
      err_f_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      imm_q       <= imm_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      assert_q    <= assert_d;
      load_q      <= load_d;
      imm_drv_q   <= imm_drv_d;
      done_q      <= done_d;
      done_data_q <= done_data_d;
      err_c_q     <= err_c_d;
      err_f_q     <= err_f_d;
    end
  end

  assign bus.req_ready      = ready_q;
  assign bus.assert_bus     = assert_q;
  assign bus.load_bus       = load_q;
  assign bus.bus_value      = bus_c;
  assign bus.done           = done_q;
  assign bus.done_data      = done_data_q;
  assign bus.err_contention = err_c_q;
  assign bus.err_float      = err_f_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: register-file environment, transaction-timeline
// reference model checked every cycle, and directed scenarios with literals.
module tb_bus_xfer_ctrl;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned N_REGS = 8;
  localparam int unsigned SEL_W  = 3;
  localparam logic [WIDTH-1:0] INIT [N_REGS] =
    '{8'h11, 8'h22, 8'h5A, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.WIDTH(WIDTH), .N_REGS(N_REGS), .SEL_W(SEL_W)) bus ();

  bus_xfer_ctrl #(.WIDTH(WIDTH), .N_REGS(N_REGS), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- register-file environment ----------------
  logic [WIDTH-1:0]  reg_file  [N_REGS];
  logic [WIDTH-1:0]  force_val [N_REGS];
  logic [N_REGS-1:0] force_en;
  logic              mute;

  always @(posedge clk) begin
    for (int i = 0; i < N_REGS; i++) begin
      if (!reset) reg_file[i] <= INIT[i];
      else if (bus.load_bus[i] === 1'b0) reg_file[i] <= bus.bus_value;
    end
  end

  always_comb begin
    bus.regs_out = '0;
    for (int i = 0; i < N_REGS; i++)
      bus.regs_out[i*WIDTH +: WIDTH] = force_en[i] ? force_val[i] : reg_file[i];
  end

  assign bus.regs_en = mute ? force_en : (~bus.assert_bus | force_en);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // A transfer accepted at edge A is in its drive phase for the two cycles
  // after A, its load phase in the second of those, and done in the third.
  logic              chk_en = 1'b0;
  logic              m_active = 1'b0;
  int                m_acc = 0;
  logic [SEL_W-1:0]  m_src, m_dst;
  logic              m_imm;
  logic [WIDTH-1:0]  m_data;
  logic              m_errc = 1'b0, m_errf = 1'b0;
  logic [WIDTH-1:0]  m_dd = '0;

  int                age, cnt;
  logic              act;
  logic [N_REGS-1:0] eab, elb, een;
  logic [WIDTH-1:0]  ebus;

  always @(negedge clk) begin
    if (chk_en) begin
      age = cyc - m_acc;
      act = m_active && (age >= 0) && (age <= 2);
      eab = '1;
      elb = '1;
      if (act && age <= 1 && !m_imm && int'(m_src) < N_REGS) eab[m_src] = 1'b0;
      if (act && age == 1 && int'(m_dst) < N_REGS) elb[m_dst] = 1'b0;
      een  = mute ? force_en : (~eab | force_en);
      ebus = '1;
      for (int i = 0; i < N_REGS; i++)
        if (een[i]) ebus = ebus & (force_en[i] ? force_val[i] : reg_file[i]);
      if (act && age <= 1 && m_imm) ebus = ebus & m_data;

      check("req_ready",      32'(bus.req_ready),      32'(!act));
      check("assert_bus",     32'(bus.assert_bus),     32'(eab));
      check("load_bus",       32'(bus.load_bus),       32'(elb));
      check("done",           32'(bus.done),           32'(act && age == 2));
      check("done_data",      32'(bus.done_data),      32'(m_dd));
      check("bus_value",      32'(bus.bus_value),      32'(ebus));
      check("err_contention", 32'(bus.err_contention), 32'(m_errc));
      check("err_float",      32'(bus.err_float),      32'(m_errf));
      check("strobe_overlap",
            32'(($countones(~bus.assert_bus) <= 1) && ($countones(~bus.load_bus) <= 1)), 32'd1);

      if (!reset) begin
        m_active = 1'b0;
        m_errc   = 1'b0;
        m_errf   = 1'b0;
        m_dd     = '0;
      end else begin
        cnt = $countones(een) + (m_imm ? 1 : 0);
        if (bus.err_clear) begin
          m_errc = 1'b0;
          m_errf = 1'b0;
        end
        if (act && age == 1) begin
          m_dd = ebus;
          if (cnt >= 2) m_errc = 1'b1;
          if (cnt == 0) m_errf = 1'b1;
        end
        if (!act && bus.req_valid) begin
          m_active = 1'b1;
          m_acc    = cyc + 1;
          m_src    = bus.req_src;
          m_dst    = bus.req_dst;
          m_imm    = bus.req_imm;
          m_data   = bus.req_data;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs one transfer; req_valid stays high with junk fields during DRIVE.
  task automatic do_xfer(input logic [SEL_W-1:0] src, input logic [SEL_W-1:0] dst,
                         input logic imm, input logic [WIDTH-1:0] data,
                         output logic [WIDTH-1:0] load_val, output logic [N_REGS-1:0] ab_and,
                         output logic done_seen, output logic [WIDTH-1:0] dd,
                         output logic ec, output logic ef);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_src   = src;
    bus.req_dst   = dst;
    bus.req_imm   = imm;
    bus.req_data  = data;
    step();
    bus.req_src   = SEL_W'($urandom);
    bus.req_dst   = SEL_W'($urandom);
    bus.req_imm   = 1'($urandom);
    bus.req_data  = WIDTH'($urandom);
    ab_and = bus.assert_bus;
    step();
    bus.req_valid = 1'b0;
    ab_and   = ab_and & bus.assert_bus;
    load_val = bus.bus_value;
    step();
    done_seen = bus.done;
    dd        = bus.done_data;
    ec        = bus.err_contention;
    ef        = bus.err_float;
    step();
  endtask

  logic [WIDTH-1:0]  lv, dd;
  logic [N_REGS-1:0] ab;
  logic              dn, ec, ef;
  int                acc_t [3];
  int                n_acc, n_done, k;

  initial begin
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_src   = '0;
    bus.req_dst   = '0;
    bus.req_imm   = 1'b0;
    bus.req_data  = '0;
    bus.err_clear = 1'b0;
    force_en      = '0;
    mute          = 1'b0;
    for (int i = 0; i < N_REGS; i++) force_val[i] = '0;
    step();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b1;
    check("rst_ready",     32'(bus.req_ready),  32'd1);
    check("rst_assert",    32'(bus.assert_bus), 32'hFF);
    check("rst_load",      32'(bus.load_bus),   32'hFF);
    check("rst_done_data", 32'(bus.done_data),  32'h00);
    step();

    // Register transfer reg2 -> reg5
    do_xfer(3'd2, 3'd5, 1'b0, 8'h00, lv, ab, dn, dd, ec, ef);
    check("x1_bus",       32'(lv),          32'h5A);
    check("x1_assert",    32'(ab),          32'hFB);
    check("x1_done",      32'(dn),          32'd1);
    check("x1_done_data", 32'(dd),          32'h5A);
    check("x1_reg5",      32'(reg_file[5]), 32'h5A);
    check("x1_errs",      32'({ec, ef}),    32'd0);

    // Immediate 0xC3 -> reg0
    do_xfer(3'd6, 3'd0, 1'b1, 8'hC3, lv, ab, dn, dd, ec, ef);
    check("imm_assert",    32'(ab),          32'hFF);
    check("imm_done",      32'(dn),          32'd1);
    check("imm_done_data", 32'(dd),          32'hC3);
    check("imm_reg0",      32'(reg_file[0]), 32'hC3);

    // Contention: reg1=0xF0 and reg3=0x3C both drive during LOAD
    force_en     = 8'b0000_1010;
    force_val[1] = 8'hF0;
    force_val[3] = 8'h3C;
    do_xfer(3'd1, 3'd6, 1'b0, 8'h00, lv, ab, dn, dd, ec, ef);
    check("cont_bus",  32'(lv),          32'h30);
    check("cont_dd",   32'(dd),          32'h30);
    check("cont_err",  32'(ec),          32'd1);
    check("cont_reg6", 32'(reg_file[6]), 32'h30);
    step();
    step();
    check("cont_sticky", 32'(bus.err_contention), 32'd1);
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    check("cont_cleared", 32'(bus.err_contention), 32'd0);

    // Clear held through a contention load: the set still wins
    bus.err_clear = 1'b1;
    do_xfer(3'd3, 3'd4, 1'b0, 8'h00, lv, ab, dn, dd, ec, ef);
    check("setwins_err", 32'(ec), 32'd1);
    check("setwins_after_clear", 32'(bus.err_contention), 32'd0);
    bus.err_clear = 1'b0;
    force_en = '0;
    step();

    // Float: nobody drives
    mute = 1'b1;
    do_xfer(3'd4, 3'd7, 1'b0, 8'h00, lv, ab, dn, dd, ec, ef);
    mute = 1'b0;
    check("float_bus", 32'(lv),          32'hFF);
    check("float_dd",  32'(dd),          32'hFF);
    check("float_err", 32'(ef),          32'd1);
    check("float_ec",  32'(ec),          32'd0);
    check("float_reg", 32'(reg_file[7]), 32'hFF);
    bus.err_clear = 1'b1;
    step();
    bus.err_clear = 1'b0;
    step();

    // Back-to-back: reg3 -> reg3 three times with req_valid held
    bus.req_valid = 1'b1;
    bus.req_src   = 3'd3;
    bus.req_dst   = 3'd3;
    bus.req_imm   = 1'b0;
    n_acc  = 0;
    n_done = 0;
    k      = 0;
    while (n_done < 3 && k < 40) begin
      if (bus.req_ready && bus.req_valid && n_acc < 3) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      step();
      if (n_acc == 3) bus.req_valid = 1'b0;
      if (bus.done) n_done++;
      k++;
    end
    bus.req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc),  32'd3);
    check("b2b_dones",   32'(n_done), 32'd3);
    check("b2b_gap1",    32'(acc_t[1] - acc_t[0]), 32'd4);
    check("b2b_gap2",    32'(acc_t[2] - acc_t[1]), 32'd4);
    check("b2b_reg3",    32'(reg_file[3]), 32'h44);
    step();

    // Reset during LOAD aborts the transfer
    bus.req_valid = 1'b1;
    bus.req_src   = 3'd2;
    bus.req_dst   = 3'd1;
    step();
    bus.req_valid = 1'b0;
    step();
    check("rl_in_load", 32'(bus.load_bus), 32'hFD);
    reset = 1'b0;
    step();
    check("rl_assert", 32'(bus.assert_bus), 32'hFF);
    check("rl_load",   32'(bus.load_bus),   32'hFF);
    check("rl_done",   32'(bus.done),       32'd0);
    reset = 1'b1;
    step();
    check("rl_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rl_no_done", 32'(bus.done), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
